muldiv_sequencer: RTL and testbench

- Multi-cycle multiply/divide sequencer that owns the HI/LO register pair for the MIPS core.
- Replaces the single-cycle HI/LO multiply path in the ALU.
- Accepts MULT/MULTU/DIV/DIVU launches from decode, iterates a shared 32-step shift/add–subtract datapath, and writes the 64-bit result to HI/LO.
- Exposes busy and stall so the pipeline holds MFHI/MFLO until the result is valid.

---
 rtl/muldiv_sequencer_if.sv | 28 ++
 rtl/muldiv_sequencer.sv | 138 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// Decode-side bundle for muldiv_sequencer: launch, MTHI/MTLO, read hold and HI/LO results.
// The master modport is the pipeline/decode side; the slave modport is the sequencer.
interface muldiv_sequencer_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        rd_req;
    logic        busy;
    logic        done;
    logic        stall;
    logic        dbz;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, mthi, mtlo, wdata, rd_req,
        input  busy, done, stall, dbz, hi, lo
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo, wdata, rd_req,
        output busy, done, stall, dbz, hi, lo
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// 33-cycle MIPS multiply/divide sequencer owning HI/LO (shared 32-step shift/add-subtract path).
// Divide hardware is built only when MULDIV_DIV_EN is defined; otherwise divides are no-ops.
module muldiv_sequencer (
    input logic               clk,
    input logic               reset,
    muldiv_sequencer_if.slave bus
);
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StFix  = 2'd2;

    logic [1:0]  state_q;
    logic [4:0]  cnt_q;
    logic [63:0] acc_q;
    logic [31:0] opnd_q;
    logic        neg_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;
    logic        dbz_q;
`ifdef MULDIV_DIV_EN
    logic        neg_rem_q;
    logic        is_div_q;
    logic [32:0] sub_diff;
`endif

    logic        idle;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] add_sum;
    logic [63:0] step;
    logic [63:0] prod;
    logic [31:0] fix_hi;
    logic [31:0] fix_lo;

    always_comb begin
        idle  = (state_q == StIdle);
        a_neg = bus.op[0] & bus.a[31];
        b_neg = bus.op[0] & bus.b[31];
        a_mag = a_neg ? -bus.a : bus.a;
        b_mag = b_neg ? -bus.b : bus.b;
    end

    // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide.
    always_comb begin
        add_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        step    = {add_sum, acc_q[31:1]};
        prod    = neg_q ? -acc_q : acc_q;
        fix_hi  = prod[63:32];
        fix_lo  = prod[31:0];
`ifdef MULDIV_DIV_EN
        sub_diff = acc_q[63:31] - {1'b0, opnd_q};
        if (is_div_q) begin
            step   = sub_diff[32] ? {acc_q[62:0], 1'b0} : {sub_diff[31:0], acc_q[30:0], 1'b1};
            fix_hi = neg_rem_q ? -acc_q[63:32] : acc_q[63:32];
            fix_lo = neg_q ? -acc_q[31:0] : acc_q[31:0];
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= 5'd0;
            acc_q     <= 64'd0;
            opnd_q    <= 32'd0;
            neg_q     <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
`ifdef MULDIV_DIV_EN
            neg_rem_q <= 1'b0;
            is_div_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        dbz_q <= 1'b0;
                        if (bus.op[1]) begin
`ifdef MULDIV_DIV_EN
                            if (bus.b == 32'd0) begin
                                dbz_q  <= 1'b1;
                                done_q <= 1'b1;
                            end else begin
                                state_q   <= StCalc;
                                cnt_q     <= 5'd31;
                                acc_q     <= {32'd0, a_mag};
                                opnd_q    <= b_mag;
                                neg_q     <= a_neg ^ b_neg;
                                neg_rem_q <= a_neg;
                                is_div_q  <= 1'b1;
                            end
`else
                            done_q <= 1'b1;
`endif
                        end else begin
                            state_q  <= StCalc;
                            cnt_q    <= 5'd31;
                            acc_q    <= {32'd0, b_mag};
                            opnd_q   <= a_mag;
                            neg_q    <= a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
                            is_div_q <= 1'b0;
`endif
                        end
                    end else begin
                        if (bus.mthi) hi_q <= bus.wdata;
                        if (bus.mtlo) lo_q <= bus.wdata;
                    end
                end
                StCalc: begin
                    acc_q <= step;
                    cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == 5'd0) state_q <= StFix;
                end
                StFix: begin
                    hi_q    <= fix_hi;
                    lo_q    <= fix_lo;
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy  = ~idle;
    assign bus.done  = done_q;
    assign bus.stall = bus.rd_req & ~idle;
    assign bus.dbz   = dbz_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus queues expected HI/LO/dbz, a monitor checks on done.
// Divide vectors run when MULDIV_DIV_EN is defined; otherwise the divide no-op path is exercised.
module tb_muldiv_sequencer;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    muldiv_sequencer_if bus();

    muldiv_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset && bus.done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 with no operation outstanding");
            end else begin
                mon_e = exp_q.pop_front();
                chk("result_hi", bus.hi, mon_e.hi);
                chk("result_lo", bus.lo, mon_e.lo);
                chk("result_dbz", {31'd0, bus.dbz}, {31'd0, mon_e.dbz});
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] ehi, input logic [31:0] elo,
                         input logic edbz, input bit mt);
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.mthi  = mt;
        bus.mtlo  = mt;
        bus.wdata = 32'hDEAD_BEEF;
        if (push) begin
            e.hi  = ehi;
            e.lo  = elo;
            e.dbz = edbz;
            exp_q.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
    endtask

    // Called at the negedge after the launch edge; counts busy cycles up to the done cycle.
    task automatic wait_done(input string name, input int exp_busy);
        int nb;
        bit got;
        nb  = 0;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            if (bus.busy) nb++;
            @(negedge clk);
        end
        chk({name, "_done_seen"}, {31'd0, got}, 32'd1);
        chk({name, "_busy_cycles"}, nb, exp_busy);
        @(negedge clk);
        chk({name, "_done_width"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  nb;
        int  stall_bad;
        bit  got;
        bus.start  = 1'b0;
        bus.op     = 2'b00;
        bus.a      = 32'd0;
        bus.b      = 32'd0;
        bus.mthi   = 1'b0;
        bus.mtlo   = 1'b0;
        bus.wdata  = 32'd0;
        bus.rd_req = 1'b0;

        repeat (2) @(negedge clk);
        chk("reset_hi", bus.hi, 32'd0);
        chk("reset_lo", bus.lo, 32'd0);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_done", {31'd0, bus.done}, 32'd0);
        chk("reset_dbz", {31'd0, bus.dbz}, 32'd0);
        reset = 1'b1;

        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);
        wait_done("multu_max", 33);

        issue(2'b01, 32'hFFFF_FFFD, 32'd7, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0);
        wait_done("mult_neg3x7", 33);

        issue(2'b01, 32'h8000_0000, 32'd2, 1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 0);
        wait_done("mult_minint", 33);

        // rd_req held from E5; spurious start + mtlo at E10 must be ignored.
        issue(2'b00, 32'h0001_0000, 32'h0001_0000, 1, 32'h0000_0001, 32'h0000_0000, 1'b0, 0);
        nb        = 0;
        stall_bad = 0;
        got       = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            if (bus.busy) nb++;
            if (cyc >= 5 && bus.stall !== 1'b1) stall_bad++;
            if (cyc == 4) bus.rd_req = 1'b1;
            if (cyc == 9) begin
                bus.start = 1'b1;
                bus.op    = 2'b00;
                bus.a     = 32'd3;
                bus.b     = 32'd3;
                bus.mtlo  = 1'b1;
                bus.wdata = 32'hDEAD_BEEF;
            end
            if (cyc == 10) begin
                bus.start = 1'b0;
                bus.mtlo  = 1'b0;
            end
            @(negedge clk);
        end
        chk("stall_done_seen", {31'd0, got}, 32'd1);
        chk("stall_busy_cycles", nb, 33);
        chk("stall_while_busy_errs", stall_bad, 0);
        chk("stall_in_done_cycle", {31'd0, bus.stall}, 32'd0);
        bus.rd_req = 1'b0;
        @(negedge clk);
        chk("stall_done_width", {31'd0, bus.done}, 32'd0);
        chk("stall_no_restart", {31'd0, bus.busy}, 32'd0);

`ifdef MULDIV_DIV_EN
        issue(2'b11, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
        wait_done("div_neg7by2", 33);

        issue(2'b10, 32'd100, 32'd0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, 1);
        wait_done("divu_by_zero", 0);
        chk("dbz_sticky", {31'd0, bus.dbz}, 32'd1);

        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000, 32'h8000_0000, 1'b0, 0);
        wait_done("div_overflow", 33);

        issue(2'b10, 32'd100, 32'd7, 1, 32'd2, 32'd14, 1'b0, 0);
        wait_done("divu_100by7", 33);

        issue(2'b11, 32'd7, 32'hFFFF_FFFE, 1, 32'd1, 32'hFFFF_FFFD, 1'b0, 0);
        wait_done("div_7byneg2", 33);
`else
        issue(2'b10, 32'd10, 32'd3, 1, 32'h0000_0001, 32'h0000_0000, 1'b0, 1);
        wait_done("divu_disabled", 0);
        chk("divu_disabled_dbz", {31'd0, bus.dbz}, 32'd0);
`endif

        @(negedge clk);
        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        bus.wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        chk("mthi_write", bus.hi, 32'hA5A5_A5A5);
        chk("mtlo_write", bus.lo, 32'hA5A5_A5A5);

        // Abort an operation with reset at E12; it must never report done.
`ifdef MULDIV_DIV_EN
        issue(2'b11, 32'hFFFF_FF9C, 32'd3, 0, 32'd0, 32'd0, 1'b0, 0);
`else
        issue(2'b01, 32'hFFFF_FF9C, 32'd3, 0, 32'd0, 32'd0, 1'b0, 0);
`endif
        repeat (11) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("abort_hi", bus.hi, 32'd0);
        chk("abort_lo", bus.lo, 32'd0);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        issue(2'b00, 32'd3, 32'd5, 1, 32'd0, 32'd15, 1'b0, 0);
        wait_done("multu_3x5", 33);

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
